// File: rtl/posit_mul_pipe.sv
// Multi-cycle posit(N,ES) multiplier: decode, multiply, normalise, round, encode.
// Define POSIT_MUL_SAT_FLAG_EN to drive SAT when the result is clamped to maxpos/minpos.
module posit_mul_pipe #(
  parameter int N  = 32,
  parameter int ES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] posit_a,
  input  logic [N-1:0] posit_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] posit_result,
  output logic         NAR,
  output logic         ZERO,
  output logic         SAT
);

  localparam int CW = $clog2(N) + 1;
  localparam int SW = $clog2(N) + ES + 3;
  localparam int PW = 2 * N - 2;
  localparam int TW = ES + 2 * N - 4;
  localparam int VW = N + TW;

  localparam logic [N-1:0] NAR_CODE = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS   = N'(1);
  localparam logic signed [SW-1:0] MAX_SCALE = SW'((N - 2) << ES);

  typedef enum logic [2:0] {IDLE, DECODE, MULT, NORM, ROUND, OUT} state_t;

  state_t state, state_next;

  logic [N-1:0]           a_reg, b_reg;
  logic                   s_a, s_b, prod_sign;
  logic signed [SW-1:0]   k_a, k_b, scale;
  logic [ES:0]            e_a, e_b;
  logic [N-2:0]           m_a, m_b;
  logic [PW-1:0]          prod;

  logic                   dsa, dsb;
  logic signed [SW-1:0]   dka, dkb;
  logic [ES:0]            dea, deb;
  logic [N-2:0]           dma, dmb;
  logic                   a_nar, b_nar, a_zero, b_zero;

  // Magnitude decode: regime run length gives k, then exponent, then fraction with hidden 1.
  function automatic void decode(input logic [N-1:0] x, output logic s,
                                 output logic signed [SW-1:0] k, output logic [ES:0] e,
                                 output logic [N-2:0] mant);
    logic [N-1:0] mag;
    logic [N-2:0] body, rem, frac;
    logic [CW-1:0] run;
    logic done;
    s    = x[N-1];
    mag  = x[N-1] ? -x : x;
    body = mag[N-2:0];
    run  = '0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && body[i] == body[N-2]) run = run + CW'(1);
      else done = 1'b1;
    end
    k    = body[N-2] ? $signed(SW'(run)) - SW'(1) : -$signed(SW'(run));
    rem  = body << (run + CW'(1));
    e    = (ES+1)'(rem >> (N - 1 - ES));
    frac = rem << ES;
    mant = {1'b1, frac[N-2:1]};
  endfunction

  always_comb begin
    decode(a_reg, dsa, dka, dea, dma);
    decode(b_reg, dsb, dkb, deb, dmb);
    a_nar  = (a_reg == NAR_CODE);
    b_nar  = (b_reg == NAR_CODE);
    a_zero = (a_reg == '0);
    b_zero = (b_reg == '0);
  end

  logic signed [SW-1:0] rk, rlen;
  logic [ES:0]          re;
  logic [N-1:0]         reg_field, rounded, mag_res, round_res;
  logic [TW-1:0]        tail;
  logic [VW-1:0]        vec;
  logic [N-2:0]         rbody;
  logic                 guard, sticky, clamp_hi, clamp_lo;

  // Lay out regime|exp|frac in a wide vector, keep N-1 body bits, round on guard/sticky.
  always_comb begin
    rk        = scale >>> ES;
    re        = (ES+1)'(scale & SW'((1 << ES) - 1));
    rlen      = !rk[SW-1] ? rk + SW'(2) : SW'(1) - rk;
    reg_field = !rk[SW-1] ? ~({N{1'b1}} >> (rk + SW'(1))) : (NAR_CODE >> (-rk));
    tail      = TW'({re, prod[PW-3:0]});
    vec       = ({tail, {N{1'b0}}} >> rlen) | {reg_field, {TW{1'b0}}};
    rbody     = vec[VW-1 -: N-1];
    guard     = vec[TW];
    sticky    = |vec[TW-1:0];
    rounded   = {1'b0, rbody} + N'(guard & (sticky | rbody[0]));
    clamp_hi  = (scale > MAX_SCALE);
    clamp_lo  = (scale < -MAX_SCALE);
    if (clamp_hi || rounded[N-1]) mag_res = MAXPOS;
    else if (clamp_lo || rounded == '0) mag_res = MINPOS;
    else mag_res = rounded;
    round_res = prod_sign ? -mag_res : mag_res;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = DECODE;
      DECODE:  state_next = (a_nar | b_nar | a_zero | b_zero) ? OUT : MULT;
      MULT:    state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      s_a          <= 1'b0;
      s_b          <= 1'b0;
      k_a          <= '0;
      k_b          <= '0;
      e_a          <= '0;
      e_b          <= '0;
      m_a          <= '0;
      m_b          <= '0;
      prod         <= '0;
      scale        <= '0;
      prod_sign    <= 1'b0;
      posit_result <= '0;
      NAR          <= 1'b0;
      ZERO         <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= posit_a;
            b_reg <= posit_b;
          end
        end
        DECODE: begin
          // NaR takes priority over zero when both appear.
          if (a_nar | b_nar) begin
            posit_result <= NAR_CODE;
            NAR          <= 1'b1;
            ZERO         <= 1'b0;
          end else if (a_zero | b_zero) begin
            posit_result <= '0;
            NAR          <= 1'b0;
            ZERO         <= 1'b1;
          end else begin
            s_a <= dsa;
            s_b <= dsb;
            k_a <= dka;
            k_b <= dkb;
            e_a <= dea;
            e_b <= deb;
            m_a <= dma;
            m_b <= dmb;
          end
        end
        MULT: begin
          prod      <= PW'(m_a) * PW'(m_b);
          scale     <= ((k_a + k_b) <<< ES) + $signed(SW'(e_a)) + $signed(SW'(e_b));
          prod_sign <= s_a ^ s_b;
        end
        NORM: begin
          if (prod[PW-1]) begin
            prod  <= {1'b0, prod[PW-1:2], prod[1] | prod[0]};
            scale <= scale + SW'(1);
          end
        end
        ROUND: begin
          posit_result <= round_res;
          NAR          <= 1'b0;
          ZERO         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef POSIT_MUL_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (state == DECODE && (a_nar | b_nar | a_zero | b_zero)) begin
      sat_q <= 1'b0;
    end else if (state == ROUND) begin
      sat_q <= clamp_hi | clamp_lo;
    end
  end

  assign SAT = sat_q;
`else
  assign SAT = 1'b0;
`endif

endmodule

// File: tb/tb_posit_mul_pipe.sv
// Self-checking bench for posit_mul_pipe (N=32, ES=3): bit-string reference model,
// per-cycle scoreboard compare, directed vectors with hand-computed results.
module tb_posit_mul_pipe;

  localparam int N  = 32;
  localparam int ES = 3;
  localparam logic [31:0] NARV = 32'h80000000;
  localparam logic [31:0] MAXP = 32'h7FFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] posit_a, posit_b, posit_result;
  logic        NAR, ZERO, SAT;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] r;
    bit          nar;
    bit          zero;
    bit          sat;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  bit   prev_valid = 1'b0;

  posit_mul_pipe #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .posit_a(posit_a), .posit_b(posit_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .posit_result(posit_result), .NAR(NAR), .ZERO(ZERO), .SAT(SAT)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // Value of a positive posit magnitude as 2^scale * sig/2^30.
  function automatic void model_decode(input logic [31:0] x, output int scale,
                                       output longint unsigned sig);
    logic [31:0] m;
    int i, run, k, e, nf;
    longint unsigned frac;
    m = x[31] ? (~x + 32'd1) : x;
    run = 0;
    i = 30;
    while (i >= 0 && m[i] == m[30]) begin
      run++;
      i--;
    end
    k = m[30] ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? int'(m[i]) : 0);
      i--;
    end
    frac = 0;
    nf = 0;
    while (i >= 0) begin
      frac = {frac[62:0], m[i]};
      nf++;
      i--;
    end
    scale = k * (1 << ES) + e;
    sig = (64'd1 << 30) | (frac << (30 - nf));
  endfunction

  // Exact product, then regime/exp/frac written out as a bit list and rounded RNE.
  function automatic void model_mul(input logic [31:0] a, input logic [31:0] b, output exp_t t);
    int sc_a, sc_b, scale, k, e, hb;
    longint unsigned sig_a, sig_b, p, body;
    bit bits[$];
    bit g, st;
    logic [31:0] mag;
    t.r = 32'h0; t.nar = 0; t.zero = 0; t.sat = 0; t.lat = 2; t.acc = 0;
    if (a == NARV || b == NARV) begin
      t.r = NARV;
      t.nar = 1;
      return;
    end
    if (a == 0 || b == 0) begin
      t.zero = 1;
      return;
    end
    t.lat = 5;
    model_decode(a, sc_a, sig_a);
    model_decode(b, sc_b, sig_b);
    p = sig_a * sig_b;
    scale = sc_a + sc_b;
    hb = 60;
    if (p[61]) begin
      hb = 61;
      scale++;
    end
    if (scale > (N - 2) * (1 << ES)) begin
      mag = MAXP;
      t.sat = 1;
    end else if (scale < -(N - 2) * (1 << ES)) begin
      mag = 32'h1;
      t.sat = 1;
    end else begin
      k = scale >>> ES;
      e = scale - (k << ES);
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int j = ES - 1; j >= 0; j--) bits.push_back(e[j]);
      for (int j = hb - 1; j >= 0; j--) bits.push_back(p[j]);
      body = 0;
      for (int j = 0; j < 31; j++) body = {body[62:0], bits[j]};
      g = bits[31];
      st = 0;
      for (int j = 32; j < bits.size(); j++) st |= bits[j];
      if (g && (st || body[0])) body++;
      if (body >= 64'h80000000) mag = MAXP;
      else if (body == 0) mag = 32'h1;
      else mag = body[31:0];
    end
    t.r = (a[31] ^ b[31]) ? (~mag + 32'd1) : mag;
  endfunction

  // Scoreboard: record at accept, compare every valid cycle, retire on handshake.
  always @(negedge clk) begin
    exp_t t;
    bit want_sat;
    if (rst) begin
      q.delete();
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check_output("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
`ifdef POSIT_MUL_SAT_FLAG_EN
          want_sat = q[0].sat;
`else
          want_sat = 1'b0;
`endif
          if (!prev_valid) check_output("latency", cyc - q[0].acc + 1, q[0].lat);
          check_output("result", posit_result, q[0].r);
          check_output("nar_flag", 32'(NAR), 32'(q[0].nar));
          check_output("zero_flag", 32'(ZERO), 32'(q[0].zero));
          check_output("sat_flag", 32'(SAT), 32'(want_sat));
          check_output("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model_mul(posit_a, posit_b, t);
        t.acc = cyc + 1;
        q.push_back(t);
      end
      prev_valid = out_valid;
    end
  end

  // One transaction; hold>0 stalls out_ready and pokes in_valid while busy.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("wait_in_ready", 32'(in_ready), 32'd1);
    posit_a  = a;
    posit_b  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    posit_a  = $urandom;
    posit_b  = $urandom;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("wait_out_valid", 32'(out_valid), 32'd1);
    if (hold > 0) begin
      in_valid = 1'b1;
      posit_a  = MAXP;
      posit_b  = MAXP;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("in_ready_after", 32'(in_ready), 32'd1);
    check_output("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  initial begin
    exp_t t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    posit_a   = 32'h0;
    posit_b   = 32'h0;
    #2;
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_result", posit_result, 32'h0);
    check_output("reset_nar", 32'(NAR), 32'd0);
    check_output("reset_zero", 32'(ZERO), 32'd0);
    check_output("reset_sat", 32'(SAT), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back('{32'h40000000, 32'h40000000, 32'h40000000, 0});
    vecs.push_back('{32'h44000000, 32'h44000000, 32'h48000000, 0});
    vecs.push_back('{32'hC0000000, 32'h44000000, 32'hBC000000, 0});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 0});
    vecs.push_back('{32'h00000000, 32'h80000000, 32'h80000000, 0});
    vecs.push_back('{32'h00000000, 32'h44000000, 32'h00000000, 0});
    vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0});
    vecs.push_back('{32'h00000001, 32'h00000001, 32'h00000001, 0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 0});
    vecs.push_back('{32'h42000000, 32'h42000000, 32'h44800000, 0});
    vecs.push_back('{32'h40000001, 32'h42000000, 32'h42000002, 0});
    vecs.push_back('{32'h40000003, 32'h42000000, 32'h42000004, 0});
    vecs.push_back('{32'h40000001, 32'h40000001, 32'h40000002, 0});
    vecs.push_back('{32'h38000000, 32'h48000000, 32'h40000000, 0});
    vecs.push_back('{32'hC0000000, 32'hC0000000, 32'h40000000, 0});
    vecs.push_back('{32'h44000000, 32'h44000000, 32'h48000000, 10});

    foreach (vecs[i]) begin
      model_mul(vecs[i].a, vecs[i].b, t);
      check_output($sformatf("model_pin_%0d", i), t.r, vecs[i].r);
    end
    model_mul(32'h00000000, 32'h80000000, t);
    check_output("model_pin_nar_wins", {t.nar, t.zero, 30'(t.lat)}, {1'b1, 1'b0, 30'd2});
    model_mul(32'h00000000, 32'h44000000, t);
    check_output("model_pin_zero", {t.nar, t.zero, 30'(t.lat)}, {1'b0, 1'b1, 30'd2});
    model_mul(32'h7FFFFFFF, 32'h7FFFFFFF, t);
    check_output("model_pin_sat_hi", 32'(t.sat), 32'd1);
    model_mul(32'h00000001, 32'h00000001, t);
    check_output("model_pin_sat_lo", 32'(t.sat), 32'd1);
    model_mul(32'h44000000, 32'h44000000, t);
    check_output("model_pin_lat", {31'(t.lat), t.sat}, {31'd5, 1'b0});

    foreach (vecs[i]) apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].hold);

    // Abort an operation in MULT, then complete a fresh one.
    posit_a  = 32'h44000000;
    posit_b  = 32'h44000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_result", posit_result, 32'h0);
    check_output("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus(32'h44000000, 32'h44000000, 0);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
